// File: rtl/code_memory_ctrl.sv
// Unified user/system code memory with IO bridge: decodes a byte address, runs a
// req/ready/valid handshake with configurable RAM read latency, alignment/protection faults and IO timeout.
module code_memory_ctrl #(
    parameter int          USER_WORDS = 4096,
    parameter int          SYS_WORDS  = 2048,
    parameter logic [31:0] IO_BASE    = 32'h1000_0000,
    parameter int          READ_LAT   = 1,
    parameter int          IO_TIMEOUT = 255
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iReq,
    input  logic        iWrite,
    input  logic [31:0] iAddress,
    input  logic [3:0]  iByteEnable,
    input  logic [31:0] iWriteData,
    input  logic        iKernel,
    output logic        oReady,
    output logic        oValid,
    output logic [31:0] oRdata,
    output logic        oFault,
    output logic [1:0]  oFaultCode,
    output logic        oIOReq,
    output logic        oIOWrite,
    output logic [31:0] oIOAddress,
    output logic [31:0] oIOWriteData,
    output logic [3:0]  oIOByteEnable,
    input  logic        iIOAck,
    input  logic [31:0] iIOData
);
    localparam int TOTAL_WORDS = USER_WORDS + SYS_WORDS;
    localparam int AW          = $clog2(TOTAL_WORDS);
    localparam int TW          = $clog2(IO_TIMEOUT + 1);
    localparam logic [29:0] USER_LIM = 30'(USER_WORDS);
    localparam logic [29:0] SYS_LIM  = 30'(TOTAL_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0, S_DONE = 2'd1, S_MEM = 2'd2, S_IO_WAIT = 2'd3;
    localparam logic [1:0] FC_TIMEOUT = 2'b00, FC_ALIGN = 2'b01, FC_UNMAP = 2'b10, FC_PROT = 2'b11;

    logic [1:0]    r_state;
    logic          r_valid, r_fault;
    logic [1:0]    r_code;
    logic [31:0]   r_rdata;
    logic [2:0]    r_lat_cnt;
    logic [AW-1:0] r_addr;
    logic          r_io_req, r_io_write;
    logic [31:0]   r_io_addr, r_io_wdata;
    logic [3:0]    r_io_be;
    logic [TW-1:0] r_io_cnt;
    logic [31:0]   r_mem [TOTAL_WORDS];

    logic [29:0]   w_word;
    logic          w_misalign, w_is_io, w_is_user, w_is_sys, w_unmap, w_prot, w_fault;
    logic [1:0]    w_code;
    logic          w_accept;
    logic [AW-1:0] w_idx;

    assign w_word     = iAddress[31:2];
    assign w_misalign = iAddress[1:0] != 2'b00;
    assign w_is_io    = iAddress >= IO_BASE;
    assign w_is_user  = !w_is_io && (w_word < USER_LIM);
    assign w_is_sys   = !w_is_io && !w_is_user && (w_word < SYS_LIM);
    assign w_unmap    = !w_is_io && !w_is_user && !w_is_sys;
    assign w_prot     = w_is_sys && !iKernel;
    assign w_fault    = w_misalign || w_unmap || w_prot;
    assign w_code     = w_misalign ? FC_ALIGN : (w_unmap ? FC_UNMAP : FC_PROT);
    assign w_accept   = iReq && (r_state == S_IDLE);
    assign w_idx      = w_word[AW-1:0];

    // RAM is deliberately not reset; writes commit on the accept edge itself.
    always_ff @(posedge iCLK) begin
        if (w_accept && iWrite && !w_fault && !w_is_io) begin
            for (int b = 0; b < 4; b++) begin
                if (iByteEnable[b]) r_mem[w_idx][8*b +: 8] <= iWriteData[8*b +: 8];
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state    <= S_IDLE;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
            r_code     <= 2'b00;
            r_rdata    <= '0;
            r_lat_cnt  <= '0;
            r_addr     <= '0;
            r_io_req   <= 1'b0;
            r_io_write <= 1'b0;
            r_io_addr  <= '0;
            r_io_wdata <= '0;
            r_io_be    <= '0;
            r_io_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    if (w_fault) begin
                        r_valid <= 1'b1;
                        r_fault <= 1'b1;
                        r_code  <= w_code;
                        r_state <= S_DONE;
                    end else if (w_is_io) begin
                        r_io_req   <= 1'b1;
                        r_io_write <= iWrite;
                        r_io_addr  <= iAddress;
                        r_io_wdata <= iWriteData;
                        r_io_be    <= iByteEnable;
                        r_io_cnt   <= '0;
                        r_state    <= S_IO_WAIT;
                    end else if (iWrite) begin
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else if (READ_LAT == 1) begin
                        r_valid <= 1'b1;
                        r_rdata <= r_mem[w_idx];
                        r_state <= S_DONE;
                    end else begin
                        r_addr    <= w_idx;
                        r_lat_cnt <= 3'd1;
                        r_state   <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (r_lat_cnt == 3'(READ_LAT - 1)) begin
                        r_valid <= 1'b1;
                        r_rdata <= r_mem[r_addr];
                        r_state <= S_DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                    end
                end
                S_IO_WAIT: begin
                    if (iIOAck) begin
                        r_io_req <= 1'b0;
                        r_valid  <= 1'b1;
                        r_rdata  <= r_io_write ? 32'h0 : iIOData;
                        r_state  <= S_DONE;
                    end else if (r_io_cnt == TW'(IO_TIMEOUT - 1)) begin
                        r_io_req <= 1'b0;
                        r_valid  <= 1'b1;
                        r_fault  <= 1'b1;
                        r_code   <= FC_TIMEOUT;
                        r_state  <= S_DONE;
                    end else begin
                        r_io_cnt <= r_io_cnt + 1'b1;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_fault <= 1'b0;
                    r_code  <= 2'b00;
                    r_rdata <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign oReady        = r_state == S_IDLE;
    assign oValid        = r_valid;
    assign oRdata        = r_rdata;
    assign oFault        = r_fault;
    assign oFaultCode    = r_code;
    assign oIOReq        = r_io_req;
    assign oIOWrite      = r_io_write;
    assign oIOAddress    = r_io_addr;
    assign oIOWriteData  = r_io_wdata;
    assign oIOByteEnable = r_io_be;
endmodule

// File: tb/tb_code_memory_ctrl.sv
// Directed scoreboard bench for code_memory_ctrl (READ_LAT=3, IO_TIMEOUT=8 build).
module tb_code_memory_ctrl;
    localparam int RL = 3;
    localparam int TO = 8;

    logic        iCLK = 0, iRST_n = 0;
    logic        iReq = 0, iWrite = 0, iKernel = 0, iIOAck = 0;
    logic [31:0] iAddress = 0, iWriteData = 0, iIOData = 0;
    logic [3:0]  iByteEnable = 0;
    logic        oReady, oValid, oFault, oIOReq, oIOWrite;
    logic [31:0] oRdata, oIOAddress, oIOWriteData;
    logic [1:0]  oFaultCode;
    logic [3:0]  oIOByteEnable;

    code_memory_ctrl #(.READ_LAT(RL), .IO_TIMEOUT(TO)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iReq(iReq), .iWrite(iWrite), .iAddress(iAddress),
        .iByteEnable(iByteEnable), .iWriteData(iWriteData), .iKernel(iKernel),
        .oReady(oReady), .oValid(oValid), .oRdata(oRdata), .oFault(oFault),
        .oFaultCode(oFaultCode), .oIOReq(oIOReq), .oIOWrite(oIOWrite),
        .oIOAddress(oIOAddress), .oIOWriteData(oIOWriteData), .oIOByteEnable(oIOByteEnable),
        .iIOAck(iIOAck), .iIOData(iIOData)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic [1:0]  code;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] rd, input logic f, input logic [1:0] c, input int lat);
        exp_t e;
        e.rdata = rd; e.fault = f; e.code = c; e.lat = lat; e.tag = tag;
        sb.push_back(e);
    endtask

    // Drives one request at a negedge; returns at the negedge of cycle 1 after accept.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d, input logic k);
        int n = 0;
        while (!oReady && n < 50) begin @(negedge iCLK); n++; end
        chk("ready_before_req", {31'b0, oReady}, 32'd1);
        iReq = 1; iWrite = wr; iAddress = a; iByteEnable = be; iWriteData = d; iKernel = k;
        @(posedge iCLK);
        @(negedge iCLK);
        iReq = 0; iWrite = 0; iByteEnable = 0; iWriteData = 0; iKernel = 0;
    endtask

    task automatic wait_resp(input int start);
        exp_t e;
        int cyc = start;
        while (!oValid && cyc < 300) begin @(negedge iCLK); cyc++; end
        if (sb.size() == 0) begin
            total++; bad++;
            $error("FAIL sb_underflow: got response with no expectation queued");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "_valid"}, {31'b0, oValid}, 32'd1);
        chk({e.tag, "_lat"}, cyc, e.lat);
        chk({e.tag, "_rdata"}, oRdata, e.rdata);
        chk({e.tag, "_fault"}, {31'b0, oFault}, {31'b0, e.fault});
        chk({e.tag, "_code"}, {30'b0, oFaultCode}, {30'b0, e.code});
        @(negedge iCLK);
        chk({e.tag, "_pulse"}, {31'b0, oValid}, 32'd0);
        chk({e.tag, "_ready_back"}, {31'b0, oReady}, 32'd1);
    endtask

    task automatic access(input string tag, input logic wr, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] d, input logic k, input logic [31:0] rd,
                          input logic f, input logic [1:0] c, input int lat);
        push(tag, rd, f, c, lat);
        issue(wr, a, be, d, k);
        wait_resp(1);
    endtask

    task automatic idle_no_valid(input string tag, input int n);
        int hits = 0;
        for (int i = 0; i < n; i++) begin @(negedge iCLK); if (oValid) hits++; end
        chk(tag, hits, 0);
    endtask

    task automatic reset_pulse(input string tag);
        iRST_n = 0;
        #1;
        chk({tag, "_ioreq"}, {31'b0, oIOReq}, 32'd0);
        chk({tag, "_valid"}, {31'b0, oValid}, 32'd0);
        chk({tag, "_ready"}, {31'b0, oReady}, 32'd1);
        @(negedge iCLK);
        iRST_n = 1;
        idle_no_valid({tag, "_quiet"}, 6);
        chk({tag, "_ready_after"}, {31'b0, oReady}, 32'd1);
    endtask

    initial begin
        int rq;
        // 1: reset state
        #3;
        chk("rst_ready", {31'b0, oReady}, 32'd1);
        chk("rst_valid", {31'b0, oValid}, 32'd0);
        chk("rst_ioreq", {31'b0, oIOReq}, 32'd0);
        chk("rst_rdata", oRdata, 32'd0);
        chk("rst_fault", {31'b0, oFault}, 32'd0);
        @(negedge iCLK); @(negedge iCLK);
        iRST_n = 1;
        idle_no_valid("rst_idle", 5);

        // 2: byte-masked write then read-back
        access("clr10", 1, 32'h10, 4'hF, 32'h0, 0, 32'h0, 0, 2'b00, 1);
        access("wr10", 1, 32'h10, 4'b0101, 32'hDEADBEEF, 0, 32'h0, 0, 2'b00, 1);
        access("rd10", 0, 32'h10, 4'h0, 32'h0, 0, 32'h00AD00EF, 0, 2'b00, RL);
        access("wr10_be0", 1, 32'h10, 4'h0, 32'hFFFFFFFF, 0, 32'h0, 0, 2'b00, 1);
        access("rd10_be0", 0, 32'h10, 4'hF, 32'h0, 0, 32'h00AD00EF, 0, 2'b00, RL);

        // 3: faults and protection
        access("misalign", 0, 32'h13, 4'h0, 32'h0, 1, 32'h0, 1, 2'b01, 1);
        access("unmap", 0, 32'h6000, 4'h0, 32'h0, 1, 32'h0, 1, 2'b10, 1);
        access("misal_over_unmap", 0, 32'h6001, 4'h0, 32'h0, 1, 32'h0, 1, 2'b01, 1);
        access("unmap_below_io", 0, 32'h0FFF_FFFC, 4'h0, 32'h0, 1, 32'h0, 1, 2'b10, 1);
        access("k_wr4000", 1, 32'h4000, 4'hF, 32'h11112222, 1, 32'h0, 0, 2'b00, 1);
        access("u_wr4000", 1, 32'h4000, 4'hF, 32'hFFFFFFFF, 0, 32'h0, 1, 2'b11, 1);
        access("u_rd4000", 0, 32'h4000, 4'h0, 32'h0, 0, 32'h0, 1, 2'b11, 1);
        access("k_rd4000", 0, 32'h4000, 4'h0, 32'h0, 1, 32'h11112222, 0, 2'b00, RL);

        // 4: region edges
        access("wr_last_sys", 1, 32'h5FFC, 4'hF, 32'h12345678, 1, 32'h0, 0, 2'b00, 1);
        access("rd_last_sys", 0, 32'h5FFC, 4'h0, 32'h0, 1, 32'h12345678, 0, 2'b00, RL);
        access("wr_last_user", 1, 32'h3FFC, 4'hF, 32'hA5A5_0F0F, 0, 32'h0, 0, 2'b00, 1);
        access("rd_last_user", 0, 32'h3FFC, 4'h0, 32'h0, 0, 32'hA5A5_0F0F, 0, 2'b00, RL);

        // stray ack while idle must be ignored
        iIOAck = 1; iIOData = 32'h1234_5678;
        idle_no_valid("stray_ack", 3);
        iIOAck = 0; iIOData = 0;
        chk("stray_ack_ready", {31'b0, oReady}, 32'd1);

        // 5: IO read with ack on cycle 7
        push("io_rd", 32'hCAFEF00D, 0, 2'b00, 8);
        issue(0, 32'h1000_0004, 4'hF, 32'h0, 0);
        chk("io_rd_req", {31'b0, oIOReq}, 32'd1);
        chk("io_rd_addr", oIOAddress, 32'h1000_0004);
        chk("io_rd_dir", {31'b0, oIOWrite}, 32'd0);
        repeat (6) @(negedge iCLK);
        chk("io_rd_req_held", {31'b0, oIOReq}, 32'd1);
        chk("io_rd_no_early_valid", {31'b0, oValid}, 32'd0);
        iIOAck = 1; iIOData = 32'hCAFEF00D;
        @(negedge iCLK);
        iIOAck = 0; iIOData = 0;
        chk("io_rd_req_drop", {31'b0, oIOReq}, 32'd0);
        wait_resp(8);

        // IO write returns zero data
        push("io_wr", 32'h0, 0, 2'b00, 2);
        issue(1, 32'h1000_0008, 4'b1100, 32'h55AA_55AA, 0);
        chk("io_wr_dir", {31'b0, oIOWrite}, 32'd1);
        chk("io_wr_data", oIOWriteData, 32'h55AA_55AA);
        chk("io_wr_be", {28'b0, oIOByteEnable}, 32'h0000_000C);
        iIOAck = 1; iIOData = 32'hFFFF_FFFF;
        @(negedge iCLK);
        iIOAck = 0; iIOData = 0;
        wait_resp(2);

        // IO timeout
        push("io_to", 32'h0, 1, 2'b00, TO + 1);
        issue(0, 32'h1000_0100, 4'hF, 32'h0, 0);
        rq = 0;
        while (oIOReq && rq < 300) begin rq++; @(negedge iCLK); end
        chk("io_to_req_cycles", rq, TO);
        wait_resp(TO + 1);

        // 6: reset mid-operation
        issue(0, 32'h1000_0004, 4'hF, 32'h0, 0);
        @(negedge iCLK);
        reset_pulse("rst_io");
        issue(0, 32'h10, 4'h0, 32'h0, 0);
        reset_pulse("rst_rd");
        access("rd10_after_rst", 0, 32'h10, 4'h0, 32'h0, 0, 32'h00AD00EF, 0, 2'b00, RL);
        access("rd_sys_after_rst", 0, 32'h5FFC, 4'h0, 32'h0, 1, 32'h12345678, 0, 2'b00, RL);

        if (sb.size() != 0) begin
            total++; bad++;
            $error("FAIL sb_leftover: got %0d entries want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
